css_gain_mult: RTL and testbench
================================

# css_gain_mult

Sequential single-precision floating-point multiplier that sits directly downstream of the cross-bridge-saturation lookup stage. It consumes the 32-bit IEEE-754 saturation term (0.0 to 1.0) and scales it by a 32-bit IEEE-754 gain, producing the scaled drive for the spindle/neuron datapath. The mantissa product is formed iteratively (shift-add), so the multiply occupies no DSP slice. A valid/ready handshake is used on both sides.

## Interface
- RADIX_BITS, 1, multiplier bits consumed per iteration; legal values 1, 2, 4, 8; iteration count N = 24/RADIX_BITS
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low; reset==0 clears all state immediately
- in_valid  in  1  css/gain operands valid
- in_ready  out  1  block idle and able to accept operands
- css  in  32  IEEE-754 saturation term (lookup-stage output)
- gain  in  32  IEEE-754 gain
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- out_data  out  32  IEEE-754 product css*gain

## Operation
- Reset values:
  - in_ready=1, out_valid=0, out_data=32'h00000000.
  - Internal state is IDLE.
- IDLE:
  - in_ready=1.
  - A transfer occurs on the edge where in_valid && in_ready.
  - On that edge the block latches sign = css[31]^gain[31].
  - It latches exp_sum = css[30:23] + gain[30:23] - 127, as a 10-bit signed value.
  - It latches mantissas {1,man} (24 bits each) and the special flags.
  - Next state is MUL.
- MUL:
  - in_ready=0.
  - Each cycle consumes RADIX_BITS of the multiplier, LSB first, into a 48-bit accumulator.
  - The state runs for exactly N cycles, then goes to NORM.
- NORM (1 cycle): result selection, in priority order:
  1. Either operand exponent field == 255: out_data = {sign, 31'h7F7FFFFF}.
  2. Either operand exponent field == 0 (zero or denormal, flushed): out_data = 32'h00000000.
  3. If P[47]=1: mant=P[46:24] and exp_sum+1. Otherwise: mant=P[45:23].
  4. Final exponent >= 255: saturate to {sign, 31'h7F7FFFFF}.
  5. Final exponent <= 0: out_data = 32'h00000000.
  6. Otherwise: out_data = {sign, exp[7:0], mant}.
  - Rounding is truncation; there is no round-to-nearest.
  - Next state is DONE, with out_valid=1.
- DONE:
  - out_valid=1.
  - out_data is stable until the edge where out_valid && out_ready; then go to IDLE.
  - in_ready=0 in DONE, so there is no overlap.
- Fixed latency: special cases still pass through MUL and NORM.
- in_valid is ignored outside IDLE.
- css and gain are sampled only on the accept edge; later changes have no effect.

## Timing
- Accept on edge k; out_valid rises on edge k+N+1 (N MUL cycles + NORM).
- Default RADIX_BITS=1: out_valid 25 edges after accept.
- RADIX_BITS=8: out_valid 4 edges after accept.
- in_ready is combinational from state (IDLE only); it does not depend on in_valid.
- If out_ready is already 1 when out_valid rises, the result is consumed on the next edge, and in_ready=1 the cycle after.
- Minimum initiation interval is N+3 cycles.
- Reset asserted mid-MUL/NORM/DONE:
  - Immediate return to IDLE, out_valid=0, out_data=0.
  - The partial result is discarded and nothing is emitted after reset release.

## Structure
- Shared package css_pkg holds:
  - FLT_EXP_BIAS=127, FLT_MAX_MAG=31'h7F7FFFFF, FLT_MAN_W=23, FLT_EXP_W=8.
  - The state enum IDLE/MUL/NORM/DONE.
  - These are reused by the lookup stage and later float stages.
- One sub-module, css_mant_mul:
  - Iterative 24x24 unsigned shift-add multiplier with start/done and RADIX_BITS parameter.
  - Outputs the 48-bit product.
- Top-level logic: handshake FSM, exponent/sign path, NORM packing.

## Test plan
- Basic multiply: css=32'h3F800000, gain=32'h40000000 → out_data=32'h40000000, with out_valid exactly 25 edges after accept (RADIX_BITS=1).
- Table entry and normalisation:
  - css=32'h3F42F7D6, gain=32'h40000000 → 32'h3FC2F7D6.
  - css=32'h3FC00000, gain=32'h3FC00000 → 32'h40100000 (P[47] path).
- Sign and zero:
  - css=32'h3F800000, gain=32'hC0000000 → 32'hC0000000.
  - css=32'h00000000, gain=32'h42C80000 → 32'h00000000 at the same fixed latency.
- Saturation and underflow:
  - css=32'h7F000000, gain=32'h40800000 → 32'h7F7FFFFF.
  - css=32'h00800000, gain=32'h00800000 → 32'h00000000.
  - Either operand exponent 255 → saturated magnitude.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid: out_valid and out_data stay stable, and in_ready stays 0.
  - in_valid pulses during MUL are ignored.
  - Releasing out_ready gives in_ready=1 one cycle after the acceptance edge.
- Reset mid-operation:
  - Pull reset low 5 cycles into MUL: out_valid and out_data clear immediately and no result appears.
  - The next transaction (1.0*2.0) completes correctly. Repeat the full test plan with RADIX_BITS=8, expecting latency 4.

Source files
------------

// File: rtl/css_pkg.sv
// Shared float constants and stage state encoding.
// Reused by the css lookup stage and downstream float stages.
package css_pkg;

  localparam int FLT_EXP_BIAS = 127;
  localparam int FLT_MAN_W = 23;
  localparam int FLT_EXP_W = 8;
  localparam logic [30:0] FLT_MAX_MAG = 31'h7F7FFFFF;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/css_mant_mul.sv
// Iterative 24x24 unsigned shift-add multiplier.
// Consumes RADIX_BITS multiplier bits per cycle, LSB first.
module css_mant_mul #(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] mcand,
  input  logic [23:0] mplier,
  output logic        done,
  output logic [47:0] prod
);

  localparam int N = 24 / RADIX_BITS;

  logic        busy;
  logic [4:0]  cnt;
  logic [47:0] acc;
  logic [47:0] a_sh;
  logic [23:0] b_sh;
  logic [47:0] part;

  // partial product of the current multiplier digit
  always_comb begin
    part = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (b_sh[i]) begin
        part = part + (a_sh << i);
      end
    end
  end

  assign done = busy && (cnt == 5'(N - 1));
  assign prod = acc;

  // accumulate one digit per cycle while busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      acc  <= '0;
      a_sh <= {24'd0, mcand};
      b_sh <= mplier;
    end else if (busy) begin
      acc  <= acc + part;
      a_sh <= a_sh << RADIX_BITS;
      b_sh <= b_sh >> RADIX_BITS;
      cnt  <= cnt + 5'd1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/css_gain_mult.sv
// Float multiplier scaling the css saturation term by a gain.
// Fixed latency: every operand pair walks MUL then NORM.
module css_gain_mult
  import css_pkg::*;
#(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] css,
  input  logic [31:0] gain,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  state_t state;
  state_t state_nx;

  logic              accept;
  logic              mul_last;
  logic [47:0]       prod;
  logic              sgn;
  logic signed [9:0] exp_sum;
  logic signed [9:0] exp_fin;
  logic              spc_inf;
  logic              spc_zero;
  logic [22:0]       mant;
  logic [31:0]       res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  css_mant_mul #(
    .RADIX_BITS(RADIX_BITS)
  ) u_mant (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .mcand ({1'b1, css[FLT_MAN_W-1:0]}),
    .mplier({1'b1, gain[FLT_MAN_W-1:0]}),
    .done  (mul_last),
    .prod  (prod)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = MUL;
      MUL:  if (mul_last) state_nx = NORM;
      NORM: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // normalise, then resolve specials and range in priority order
  always_comb begin
    exp_fin = exp_sum + (prod[47] ? 10'sd1 : 10'sd0);
    mant    = prod[47] ? prod[46:24] : prod[45:23];
    if (spc_inf) begin
      res = {sgn, FLT_MAX_MAG};
    end else if (spc_zero) begin
      res = '0;
    end else if (exp_fin >= 10'sd255) begin
      res = {sgn, FLT_MAX_MAG};
    end else if (exp_fin <= 10'sd0) begin
      res = '0;
    end else begin
      res = {sgn, exp_fin[FLT_EXP_W-1:0], mant};
    end
  end

  // sign/exponent capture on accept, result capture in NORM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sgn      <= 1'b0;
      exp_sum  <= '0;
      spc_inf  <= 1'b0;
      spc_zero <= 1'b0;
      out_data <= '0;
    end else begin
      if (accept) begin
        sgn      <= css[31] ^ gain[31];
        exp_sum  <= $signed({2'b00, css[30:23]})
                  + $signed({2'b00, gain[30:23]})
                  - 10'(FLT_EXP_BIAS);
        spc_inf  <= (css[30:23] == 8'hFF) || (gain[30:23] == 8'hFF);
        spc_zero <= (css[30:23] == 8'h00) || (gain[30:23] == 8'h00);
      end
      if (state == NORM) begin
        out_data <= res;
      end
    end
  end

endmodule

// File: tb/tb_css_gain_mult.sv
// Bench for css_gain_mult at RADIX_BITS 1 and 8.
// Results checked against an arithmetic float model.
module tb_css_gain_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        iv[2];
  logic        ir[2];
  logic        ov[2];
  logic        ordy[2];
  logic [31:0] c[2];
  logic [31:0] g[2];
  logic [31:0] od[2];

  int n_chk  = 0;
  int n_fail = 0;

  css_gain_mult #(.RADIX_BITS(1)) u_r1 (
    .clk      (clk),
    .reset    (rst[0]),
    .in_valid (iv[0]),
    .in_ready (ir[0]),
    .css      (c[0]),
    .gain     (g[0]),
    .out_valid(ov[0]),
    .out_ready(ordy[0]),
    .out_data (od[0])
  );

  css_gain_mult #(.RADIX_BITS(8)) u_r8 (
    .clk      (clk),
    .reset    (rst[1]),
    .in_valid (iv[1]),
    .in_ready (ir[1]),
    .css      (c[1]),
    .gain     (g[1]),
    .out_valid(ov[1]),
    .out_ready(ordy[1]),
    .out_data (od[1])
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fmul_ref(input logic [31:0] a,
                                           input logic [31:0] b);
    int              ea;
    int              eb;
    int              e;
    longint unsigned ma;
    longint unsigned mb;
    longint unsigned p;
    logic            s;
    logic [22:0]     m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {s, 31'h7F7FFFFF};
    if (ea == 0 || eb == 0) return 32'h0;
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin
      e++;
      m = 23'(p >> 24);
    end else begin
      m = 23'(p >> 23);
    end
    if (e >= 255) return {s, 31'h7F7FFFFF};
    if (e <= 0) return 32'h0;
    return {s, 8'(e), m};
  endfunction

  task automatic wait_idle(input int d);
    int w = 0;
    while (!ir[d] && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("idle_ready", 32'(ir[d]), 32'd1);
  endtask

  task automatic run_op(input int d,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input bit bp);
    int          lat;
    int          nn;
    logic [31:0] r;
    nn = (d == 0) ? 24 : 3;
    r  = fmul_ref(a, b);
    wait_idle(d);
    iv[d] = 1'b1;
    c[d]  = a;
    g[d]  = b;
    @(posedge clk);
    #1;
    iv[d]   = 1'b0;
    c[d]    = $urandom;
    g[d]    = $urandom;
    ordy[d] = !bp;
    lat     = 0;
    while (!ov[d] && lat < 100) begin
      if (bp) begin
        iv[d] = 1'($urandom_range(0, 1));
        c[d]  = $urandom;
        g[d]  = $urandom;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    iv[d] = 1'b0;
    check("latency", 32'(lat), 32'(nn + 1));
    check("busy_ready", 32'(ir[d]), 32'd0);
    check("result", od[d], r);
    if (bp) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        check("hold_valid", 32'(ov[d]), 32'd1);
        check("hold_data", od[d], r);
        check("hold_ready", 32'(ir[d]), 32'd0);
      end
    end
    ordy[d] = 1'b1;
    @(posedge clk);
    #1;
    ordy[d] = 1'b0;
    check("drain_valid", 32'(ov[d]), 32'd0);
    check("drain_ready", 32'(ir[d]), 32'd1);
  endtask

  task automatic reset_mid(input int d);
    int seen = 0;
    wait_idle(d);
    iv[d] = 1'b1;
    c[d]  = 32'h3F800000;
    g[d]  = 32'h40000000;
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    repeat ((d == 0) ? 5 : 2) @(posedge clk);
    #1;
    rst[d] = 1'b0;
    #1;
    check("rst_valid", 32'(ov[d]), 32'd0);
    check("rst_data", od[d], 32'h0);
    check("rst_ready", 32'(ir[d]), 32'd1);
    @(posedge clk);
    #2;
    rst[d] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (ov[d]) seen++;
    end
    check("no_ghost", 32'(seen), 32'd0);
    run_op(d, 32'h3F800000, 32'h40000000, 1'b0);
  endtask

  logic [31:0] dir_a[9];
  logic [31:0] dir_b[9];

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    dir_a = '{32'h3F800000, 32'h3F42F7D6, 32'h3FC00000, 32'h3F800000,
              32'h00000000, 32'h7F000000, 32'h00800000, 32'h7F800000,
              32'h3F000000};
    dir_b = '{32'h40000000, 32'h40000000, 32'h3FC00000, 32'hC0000000,
              32'h42C80000, 32'h40800000, 32'h00800000, 32'h3F800000,
              32'hFFC00000};
    for (int d = 0; d < 2; d++) begin
      rst[d]  = 1'b1;
      iv[d]   = 1'b0;
      ordy[d] = 1'b0;
      c[d]    = '0;
      g[d]    = '0;
    end
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    #10;
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", 32'(ir[d]), 32'd1);
      check("reset_valid", 32'(ov[d]), 32'd0);
      check("reset_data", od[d], 32'h0);
    end
    @(posedge clk);
    #2;
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 9; i++) begin
        run_op(d, dir_a[i], dir_b[i], 1'b0);
      end
      run_op(d, 32'h3F42F7D6, 32'h40000000, 1'b1);
      reset_mid(d);
      for (int i = 0; i < 40; i++) begin
        ra = {1'b0, 8'($urandom_range(100, 127)), 23'($urandom)};
        case (i % 5)
          0: rb = $urandom;
          1: rb = {1'($urandom), 8'($urandom_range(0, 1) * 255), 23'($urandom)};
          default: rb = {1'($urandom), 8'($urandom_range(90, 160)), 23'($urandom)};
        endcase
        run_op(d, ra, rb, (i % 7) == 3);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
